// File: rtl/mem_read_arbiter_pkg.sv
// mem_read_arbiter_pkg: shared defaults, state encoding and pointer-width helper
package mem_read_arbiter_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 65;
  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_read_arbiter_rr_picker.sv
// mem_read_arbiter_rr_picker: first requester at or above ptr (mod NREQ) as one-hot grant
module mem_read_arbiter_rr_picker
  import mem_read_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PTRW = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PTRW-1:0] idx,
  output logic            any
);
  logic [PTRW-1:0] j;
  // scan from farthest to nearest so the requester closest to ptr is written last and wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = PTRW'((int'(ptr) + k) % NREQ);
      if (req[j]) begin
        gnt = NREQ'(1) << j;
        idx = j;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: round-robin sharing of a 1-cycle-latency read port among NREQ requesters
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  localparam int PTRW = ptr_width(NREQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]  req_ready,
  output logic [NREQ-1:0]  resp_valid,
  input  logic [NREQ-1:0]  resp_ready,
  output logic [DW-1:0]    resp_data,
  output logic             mem_ren,
  output logic [AW-1:0]    mem_raddr,
  input  logic [DW-1:0]    mem_rdata
);
  state_t state, state_n;
  logic [PTRW-1:0] owner, owner_n, rr_ptr, rr_ptr_n, idx;
  logic [NREQ-1:0] gnt;
  logic any, retire, can_issue, accept;
  mem_read_arbiter_rr_picker #(.NREQ(NREQ), .PTRW(PTRW)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(idx),
    .any(any)
  );
  assign retire = (state == PEND) && resp_ready[owner];
  assign can_issue = !reset && ((state == IDLE) || retire);
  assign accept = can_issue && any;
  // state register: pending flag, response owner and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      rr_ptr <= rr_ptr_n;
    end
  end
  // next state: an accept keeps the slot busy even while the old response retires
  always_comb begin
    state_n = accept ? PEND : retire ? IDLE : state;
    owner_n = accept ? idx : owner;
    rr_ptr_n = !accept ? rr_ptr : (idx == PTRW'(NREQ - 1)) ? '0 : idx + 1'b1;
  end
  // outputs: grant and memory read on accept, response steered to the owner while pending
  always_comb begin
    req_ready = can_issue ? gnt : '0;
    mem_ren = accept;
    mem_raddr = accept ? req_addr[idx*AW +: AW] : '0;
    resp_valid = (!reset && state == PEND) ? NREQ'(1) << owner : '0;
    resp_data = mem_rdata;
  end
endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter: directed stimulus with a behavioural model checked every cycle
module tb_mem_read_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] req_valid, req_ready, resp_valid, resp_ready;
  logic [N*8-1:0] req_addr;
  logic [64:0] resp_data, mem_rdata;
  logic mem_ren;
  logic [7:0] mem_raddr;
  int checks = 0;
  int errors = 0;
  mem_read_arbiter #(.NREQ(N), .AW(8), .DW(65)) u_dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .mem_ren(mem_ren),
    .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  function automatic logic [64:0] mval(input logic [7:0] a);
    return {a[1], {4{a}}, 24'h5A5A5A, a};
  endfunction
  // memory with a registered address: data appears the cycle after mem_ren
  always @(posedge clk) if (mem_ren) mem_rdata <= mval(mem_raddr);
  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // reference model: one outstanding read, round-robin from the requester after the last winner
  bit m_pend = 0;
  int m_owner = 0, m_ptr = 0;
  logic [7:0] m_addr = '0;
  always @(negedge clk) begin
    logic [N-1:0] er, ev;
    logic [7:0] ea;
    int g;
    bit ci;
    g = -1;
    er = '0;
    ev = '0;
    ea = '0;
    if (!reset) begin
      ci = !m_pend || resp_ready[m_owner];
      if (ci) for (int k = 0; k < N; k++) if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      if (g >= 0) begin
        er[g] = 1'b1;
        ea = req_addr[g*8 +: 8];
      end
      if (m_pend) ev[m_owner] = 1'b1;
    end
    chk("model req_ready", 65'(req_ready), 65'(er));
    chk("model mem_ren", 65'(mem_ren), 65'(g >= 0));
    chk("model mem_raddr", 65'(mem_raddr), 65'(ea));
    chk("model resp_valid", 65'(resp_valid), 65'(ev));
    if (!reset && m_pend) chk("model resp_data", resp_data, mval(m_addr));
    if (reset) begin
      m_pend = 0;
      m_owner = 0;
      m_ptr = 0;
    end else if (g >= 0) begin
      m_pend = 1;
      m_owner = g;
      m_ptr = (g + 1) % N;
      m_addr = ea;
    end else if (m_pend && resp_ready[m_owner]) m_pend = 0;
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [64:0] d0;
    logic [N-1:0] seq [4];
    seq[0] = 4'b0010; seq[1] = 4'b0001; seq[2] = 4'b0010; seq[3] = 4'b0001;
    reset = 1'b1;
    req_valid = 4'b0011;
    req_addr = '0;
    resp_ready = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset req_ready", 65'(req_ready), 65'd0);
      chk("reset mem_ren", 65'(mem_ren), 65'd0);
      chk("reset resp_valid", 65'(resp_valid), 65'd0);
      cyc();
    end
    reset = 1'b0;
    req_valid = 4'b0001;
    req_addr[7:0] = 8'h12;
    resp_ready = 4'b0001;
    @(negedge clk);
    chk("single mem_ren", 65'(mem_ren), 65'd1);
    chk("single mem_raddr", 65'(mem_raddr), 65'h12);
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk("single resp_valid", 65'(resp_valid), 65'b0001);
    chk("single resp_data", resp_data, {1'b1, 32'h12121212, 24'h5A5A5A, 8'h12});
    cyc();
    req_valid = 4'b0011;
    req_addr[7:0] = 8'h20;
    req_addr[15:8] = 8'h31;
    resp_ready = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fair grant", 65'(req_ready), 65'(seq[i]));
      chk("fair mem_ren", 65'(mem_ren), 65'd1);
      cyc();
    end
    req_valid = '0;
    cyc();
    resp_ready = 4'b0010;
    req_valid = 4'b0001;
    req_addr[7:0] = 8'h44;
    @(negedge clk);
    chk("bp grant", 65'(req_ready), 65'b0001);
    cyc();
    req_valid = 4'b0011;
    req_addr[15:8] = 8'h66;
    @(negedge clk);
    d0 = resp_data;
    chk("bp data", d0, {1'b0, 32'h44444444, 24'h5A5A5A, 8'h44});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp resp_valid", 65'(resp_valid), 65'b0001);
      chk("bp req_ready", 65'(req_ready), 65'd0);
      chk("bp stable", resp_data, d0);
      cyc();
    end
    resp_ready = 4'b0001;
    @(negedge clk);
    chk("bp regrant", 65'(req_ready), 65'b0010);
    chk("bp raddr", 65'(mem_raddr), 65'h66);
    cyc();
    req_valid = '0;
    resp_ready = 4'b1111;
    @(negedge clk);
    chk("bp resp1", 65'(resp_valid), 65'b0010);
    cyc();
    req_valid = 4'b1000;
    req_addr[31:24] = 8'h7E;
    @(negedge clk);
    chk("wrap grant3", 65'(req_ready), 65'b1000);
    cyc();
    req_valid = 4'b1111;
    @(negedge clk);
    chk("wrap grant0", 65'(req_ready), 65'b0001);
    cyc();
    req_valid = 4'b0010;
    req_addr[15:8] = 8'h55;
    @(negedge clk);
    chk("midrst grant1", 65'(req_ready), 65'b0010);
    cyc();
    reset = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("midrst resp_valid", 65'(resp_valid), 65'd0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst after", 65'(resp_valid), 65'd0);
    cyc();
    req_valid = 4'b0011;
    @(negedge clk);
    chk("midrst ptr0", 65'(req_ready), 65'b0001);
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
